// File: rtl/ddu_ctrl_if.sv
// ddu_ctrl_if: debug-side bundle between the DDU controller and the CPU.
// master = DDU controller, slave = CPU / memory read ports.
interface ddu_ctrl_if;
  logic        run;
  logic        cont;
  logic [7:0]  ddu_addr;
  logic [31:0] reg_data;
  logic [31:0] mem_data;
  logic [31:0] disp_data;
  logic [15:0] step_count;

  modport master (
    output run,
    output cont,
    output ddu_addr,
    output disp_data,
    output step_count,
    input  reg_data,
    input  mem_data
  );

  modport slave (
    input  run,
    input  cont,
    input  ddu_addr,
    input  disp_data,
    input  step_count,
    output reg_data,
    output mem_data
  );
endinterface

// File: rtl/ddu_ctrl.sv
// ddu_ctrl: board switches/buttons to CPU run/step/browse controls.
// Synchronizes, debounces, edge-detects and drives the display word.
module ddu_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic run_sw,
  input  logic step_btn,
  input  logic inc_btn,
  input  logic dec_btn,
  input  logic mem_sel,
  ddu_ctrl_if.master bus
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CMAX =
    CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {
    REG = 1'b0,
    MEM = 1'b1
  } state_t;

  // bit order: 0 run, 1 step, 2 inc, 3 dec, 4 mem_sel
  logic [4:0] raw;
  logic [4:0] s1;
  logic [4:0] s2;

  assign raw = {mem_sel, dec_btn, inc_btn,
                step_btn, run_sw};

  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
    end
  end

  logic [2:0] btn;
  logic [2:0] st;
  logic [2:0] st_q;
  logic [2:0] pls;

  assign btn = s2[3:1];

  for (genvar i = 0; i < 3; i++) begin : g_db
    logic          lvl;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
      if (rst) begin
        lvl <= 1'b0;
        cnt <= '0;
      end else if (btn[i] == lvl) begin
        cnt <= '0;
      end else if (cnt == CMAX) begin
        lvl <= btn[i];
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end

    assign st[i] = lvl;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q <= '0;
      pls  <= '0;
    end else begin
      st_q <= st;
      pls  <= st & ~st_q;
    end
  end

  logic p_step;
  logic p_inc;
  logic p_dec;
  logic run_s;
  logic mem_s;
  logic cont_w;

  assign p_step = pls[0];
  assign p_inc  = pls[1];
  assign p_dec  = pls[2];
  assign run_s  = s2[0];
  assign mem_s  = s2[4];

  // a step press while running is dropped, not queued
  assign cont_w = p_step & ~run_s;

  logic [15:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (cont_w) begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

  state_t     state_q;
  state_t     state_d;
  logic [7:0] addr_q;
  logic [7:0] addr_d;
  logic [4:0] reg_inc;
  logic [4:0] reg_dec;

  assign reg_inc = addr_q[4:0] + 5'd1;
  assign reg_dec = addr_q[4:0] - 5'd1;

  always_comb begin
    state_d = mem_s ? MEM : REG;
    addr_d  = addr_q;
    if (state_d != state_q) begin
      addr_d = '0;
    end else if (p_inc ^ p_dec) begin
      unique case (state_q)
        REG: addr_d = {3'b000,
                       p_inc ? reg_inc : reg_dec};
        MEM: addr_d = p_inc ? addr_q + 8'd1
                            : addr_q - 8'd1;
        default: addr_d = addr_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= REG;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
    end
  end

  logic [31:0] disp_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      disp_q <= '0;
    end else begin
      disp_q <= (state_q == MEM) ? bus.mem_data
                                 : bus.reg_data;
    end
  end

  assign bus.run        = run_s;
  assign bus.cont       = cont_w;
  assign bus.ddu_addr   = addr_q;
  assign bus.disp_data  = disp_q;
  assign bus.step_count = cnt_q;

endmodule

// File: tb/tb_ddu_ctrl.sv
// tb_ddu_ctrl: table-driven browse vectors plus a cont-pulse scoreboard.
// Expected pulse cycles are queued at press time and popped on cont.
module tb_ddu_ctrl;
  localparam int D = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic run_sw = 1'b0;
  logic step_btn = 1'b0;
  logic inc_btn = 1'b0;
  logic dec_btn = 1'b0;
  logic mem_sel = 1'b0;

  ddu_ctrl_if bus();

  ddu_ctrl #(.DEBOUNCE_CYCLES(D)) dut (
    .clk      (clk),
    .rst      (rst),
    .run_sw   (run_sw),
    .step_btn (step_btn),
    .inc_btn  (inc_btn),
    .dec_btn  (dec_btn),
    .mem_sel  (mem_sel),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  int exp_q[$];

  // scoreboard: every cont pulse must match the queued cycle
  always @(negedge clk) begin
    int e;
    if (bus.cont === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL cont_unexpected: pulse at cyc %0d, none expected",
                 cyc);
      end else begin
        e = exp_q.pop_front();
        if (e != cyc) begin
          errors++;
          $display("FAIL cont_timing: pulse at cyc %0d, expected cyc %0d",
                   cyc, e);
        end
      end
    end
  end

  task automatic chk(string name, logic [31:0] act,
                     logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic nclk(int n);
    repeat (n) @(negedge clk);
  endtask

  // b = {dec, inc, step}; called and returns at a negedge
  task automatic press(logic [2:0] b, bit pulse, int hold);
    {dec_btn, inc_btn, step_btn} = b;
    if (pulse) exp_q.push_back(cyc + D + 3);
    nclk(hold);
    {dec_btn, inc_btn, step_btn} = 3'b000;
    nclk(D + 6);
  endtask

  typedef struct {
    logic       mem;
    logic [2:0] btn;
    logic [7:0] addr;
  } vec_t;

  vec_t tv[12];

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish, expected finish");
    $fatal(1);
  end

  initial begin
    tv[0]  = '{1'b0, 3'b100, 8'd31};
    tv[1]  = '{1'b0, 3'b010, 8'd0};
    tv[2]  = '{1'b0, 3'b010, 8'd1};
    tv[3]  = '{1'b0, 3'b110, 8'd1};
    tv[4]  = '{1'b1, 3'b000, 8'd0};
    tv[5]  = '{1'b1, 3'b100, 8'd255};
    tv[6]  = '{1'b1, 3'b010, 8'd0};
    tv[7]  = '{1'b1, 3'b010, 8'd1};
    tv[8]  = '{1'b1, 3'b110, 8'd1};
    tv[9]  = '{1'b1, 3'b100, 8'd0};
    tv[10] = '{1'b0, 3'b000, 8'd0};
    tv[11] = '{1'b0, 3'b100, 8'd31};

    bus.reg_data = '0;
    bus.mem_data = '0;

    // reset
    nclk(3);
    chk("rst_run", {31'd0, bus.run}, 32'd0);
    chk("rst_cont", {31'd0, bus.cont}, 32'd0);
    chk("rst_addr", {24'd0, bus.ddu_addr}, 32'd0);
    chk("rst_disp", bus.disp_data, 32'd0);
    chk("rst_count", {16'd0, bus.step_count}, 32'd0);
    rst = 1'b0;
    nclk(2);

    // single steps
    press(3'b001, 1'b1, 20);
    chk("step_count_1", {16'd0, bus.step_count}, 32'd1);
    press(3'b001, 1'b1, 10);
    chk("step_count_2", {16'd0, bus.step_count}, 32'd2);

    // bounce then hold
    step_btn = 1'b1; nclk(2);
    step_btn = 1'b0; nclk(2);
    step_btn = 1'b1; nclk(2);
    step_btn = 1'b0; nclk(2);
    step_btn = 1'b1;
    exp_q.push_back(cyc + D + 3);
    nclk(12);
    step_btn = 1'b0;
    nclk(D + 6);
    chk("bounce_count", {16'd0, bus.step_count}, 32'd3);

    // step while running is dropped
    run_sw = 1'b1;
    nclk(2);
    chk("run_high", {31'd0, bus.run}, 32'd1);
    press(3'b001, 1'b0, 10);
    chk("run_step_count", {16'd0, bus.step_count}, 32'd3);
    run_sw = 1'b0;
    nclk(3);
    chk("run_low", {31'd0, bus.run}, 32'd0);

    // browse vectors
    for (int i = 0; i < 12; i++) begin
      if (mem_sel != tv[i].mem) begin
        mem_sel = tv[i].mem;
        nclk(4);
      end
      if (tv[i].btn != 3'b000) press(tv[i].btn, 1'b0, 10);
      chk($sformatf("addr_vec%0d", i),
          {24'd0, bus.ddu_addr}, {24'd0, tv[i].addr});
    end

    // mode switch latency and display source
    bus.reg_data = 32'h1234_5678;
    bus.mem_data = 32'hDEAD_BEEF;
    mem_sel = 1'b1;
    nclk(2);
    chk("mode_lat_pre", {24'd0, bus.ddu_addr}, 32'd31);
    chk("disp_reg", bus.disp_data, 32'h1234_5678);
    nclk(1);
    chk("mode_lat_post", {24'd0, bus.ddu_addr}, 32'd0);
    nclk(1);
    chk("disp_mem", bus.disp_data, 32'hDEAD_BEEF);
    bus.mem_data = 32'hCAFE_F00D;
    nclk(1);
    chk("disp_mem_lag", bus.disp_data, 32'hCAFE_F00D);
    mem_sel = 1'b0;
    nclk(4);
    chk("disp_back_reg", bus.disp_data, 32'h1234_5678);
    chk("addr_back_reg", {24'd0, bus.ddu_addr}, 32'd0);

    // reset while step held mid-count
    step_btn = 1'b1;
    nclk(4);
    rst = 1'b1;
    nclk(3);
    chk("midrst_count", {16'd0, bus.step_count}, 32'd0);
    rst = 1'b0;
    exp_q.push_back(cyc + D + 3);
    nclk(12);
    step_btn = 1'b0;
    nclk(D + 6);
    chk("midrst_count_after", {16'd0, bus.step_count}, 32'd1);

    chk("pending_pulses", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
